fetch_queue: RTL and testbench

Instruction prefetch queue sitting directly downstream of the instruction fetch unit and upstream of decode. It captures {PC, instruction} pairs produced by fetch into a small circular buffer so fetch can continue while decode is stalled. It drives the fetch unit's PC write-enable through `in_ready`, and discards all buffered work on a control-flow redirect.

---
 rtl/fetch_queue_pkg.sv | 18 +
 rtl/fetch_queue.sv | 70 +++++++
 tb/tb_fetch_queue.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_queue_pkg : fetch/decode shared types and constants             |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
package fetch_queue_pkg;

  localparam logic [31:0] INIT_PC = 32'h0000_3000;
  localparam int          INSTR_W = 32;
  localparam int          PC_W    = 32;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_queue : circular prefetch buffer between fetch and decode       |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  output logic               out_valid,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   count
);

  localparam int               c_PTR_W   = $clog2(DEPTH);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
  localparam logic [CNT_W-1:0] c_FULL    = CNT_W'(DEPTH);

  fetch_entry         r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic       w_push;
  logic       w_pop;
  fetch_entry w_head;

  // Ready/valid come from registered occupancy only, so a full queue
  // never passes a new pair through in the same cycle as a pop.
  assign in_ready  = (r_count < c_FULL);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready & ~flush;
  assign w_head    = r_mem[r_rd_ptr];
  assign out_pc    = out_valid ? w_head.pc    : '0;
  assign out_instr = out_valid ? w_head.instr : '0;
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Storage is not cleared on reset/flush; stale entries are unreachable.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[r_wr_ptr] <= '{pc: in_pc, instr: in_instr};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_queue : directed + random checks against a queue model       |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               flush = 1'b0;
  logic               in_valid = 1'b0;
  logic [PC_W-1:0]    in_pc = '0;
  logic [INSTR_W-1:0] in_instr = '0;
  logic               in_ready;
  logic               out_valid;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic               out_ready = 1'b0;
  logic [CNT_W-1:0]   count;

  int tests = 0;
  int fails = 0;
  fetch_entry model_q[$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model rules: reset/flush empty the queue; otherwise pop the head if
  // non-empty and decode is ready, push if there was room before the edge.
  task automatic model_edge();
    int sz = model_q.size();
    if (reset || flush) begin
      model_q.delete();
    end else begin
      if (sz != 0 && out_ready) void'(model_q.pop_front());
      if (in_valid && sz < DEPTH) model_q.push_back('{pc: in_pc, instr: in_instr});
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] epc = (model_q.size() != 0) ? model_q[0].pc : 32'h0;
    logic [31:0] ein = (model_q.size() != 0) ? model_q[0].instr : 32'h0;
    chk({tag, ".count"},     64'(count),     64'(model_q.size()));
    chk({tag, ".in_ready"},  64'(in_ready),  64'(model_q.size() < DEPTH));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(model_q.size() != 0));
    chk({tag, ".out_pc"},    64'(out_pc),    64'(epc));
    chk({tag, ".out_instr"}, 64'(out_instr), 64'(ein));
  endtask

  task automatic step(input string tag, input logic r, input logic f, input logic iv,
                      input logic [31:0] pc, input logic [31:0] ins, input logic ordy);
    @(negedge clk);
    reset = r; flush = f; in_valid = iv; in_pc = pc; in_instr = ins; out_ready = ordy;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] pc;
    // Reset
    step("reset", 1, 0, 0, 0, 0, 0);
    chk("reset.pc_zero", 64'(out_pc), 64'h0);

    // Three pushes, decode stalled
    step("push0", 0, 0, 1, 32'h3000, 32'h24010001, 0);
    chk("push0.latency_valid", 64'(out_valid), 64'h1);
    step("push1", 0, 0, 1, 32'h3004, 32'h24020002, 0);
    step("push2", 0, 0, 1, 32'h3008, 32'h24030003, 0);
    chk("three.out_pc", 64'(out_pc), 64'h3000);
    chk("three.out_instr", 64'(out_instr), 64'h24010001);

    // Fill, then hold a 5th offer for 2 cycles
    step("push3", 0, 0, 1, 32'h300c, 32'h24040004, 0);
    chk("full.in_ready", 64'(in_ready), 64'h0);
    step("hold5a", 0, 0, 1, 32'h3010, 32'h24050005, 0);
    step("hold5b", 0, 0, 1, 32'h3010, 32'h24050005, 0);
    chk("full.count", 64'(count), 64'h4);
    step("pop_full", 0, 0, 0, 0, 0, 1);
    chk("pop_full.out_pc", 64'(out_pc), 64'h3004);
    chk("pop_full.count", 64'(count), 64'h3);

    // Drain, then streaming push+pop through several wraps
    for (int i = 0; i < 3; i++) step("drain", 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      pc = 32'h3000 + 32'(i * 4);
      step("stream", 0, 0, 1, pc, 32'h2400_0000 | 32'(i), 1);
      chk("stream.pc_order", 64'(out_pc), 64'(pc));
    end
    step("stream_end", 0, 0, 0, 0, 0, 1);

    // Flush at count=3 with a concurrent push and pop
    for (int i = 0; i < 3; i++) step("prefl", 0, 0, 1, 32'h3000 + 32'(i * 4), 32'(i), 0);
    step("flush", 0, 1, 1, 32'h300c, 32'h1234, 1);
    chk("flush.count", 64'(count), 64'h0);
    step("postfl", 0, 0, 0, 0, 0, 1);

    // Reset together with flush and push at count=2
    step("prer0", 0, 0, 1, 32'h3100, 32'h1, 0);
    step("prer1", 0, 0, 1, 32'h3104, 32'h2, 0);
    step("rst_mid", 1, 1, 1, 32'h3108, 32'h3, 1);
    step("after_rst", 0, 0, 1, 32'h3000, 32'h24010001, 0);
    chk("after_rst.first", 64'(out_pc), 64'h3000);
    step("drain1", 0, 0, 0, 0, 0, 1);

    // Empty queue with decode ready
    for (int i = 0; i < 5; i++) step("idle", 0, 0, 0, 0, 0, 1);
    chk("idle.out_valid", 64'(out_valid), 64'h0);

    // Random traffic
    pc = INIT_PC;
    for (int i = 0; i < 400; i++) begin
      logic iv  = 1'($urandom_range(0, 99) < 60);
      logic ord = 1'($urandom_range(0, 99) < 50);
      logic fl  = 1'($urandom_range(0, 31) == 0);
      logic rs  = 1'($urandom_range(0, 99) == 0);
      step("rand", rs, fl, iv, pc, $urandom, ord);
      pc = pc + 32'h4;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
